// File: rtl/full_adder_structural.sv
// rtl/full_adder_structural.sv - gate-level full adder with registered outputs and saturating carry counter
//
// half_adder
//   a_i, b_i   : addend bits
//   sum_o      : a_i ^ b_i (xor primitive)
//   carry_o    : a_i & b_i (and primitive)
//
// full_adder_structural
//   CNT_W      : width of carry-event counter (2..16)
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
//   A, B, Cin  : addend bits and carry-in
//   Sum, Cout  : combinational full-adder result
//   Sum_q      : Sum sampled at last rising edge
//   Cout_q     : Cout sampled at last rising edge
//   carry_cnt  : saturating count of edges that sampled Cout=1
//   carry_sat  : high while carry_cnt is all-ones

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);

  xor g_xor (sum_o, a_i, b_i);
  and g_and (carry_o, a_i, b_i);

endmodule

module full_adder_structural #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             Cin,
  output logic             Sum,
  output logic             Cout,
  output logic             Sum_q,
  output logic             Cout_q,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             carry_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wire ha1_sum;
  wire ha1_carry;
  wire ha2_carry;

  // Stage 1 adds the two addends; stage 2 folds in the carry-in.
  half_adder u_ha1 (
    .a_i     (A),
    .b_i     (B),
    .sum_o   (ha1_sum),
    .carry_o (ha1_carry)
  );

  half_adder u_ha2 (
    .a_i     (ha1_sum),
    .b_i     (Cin),
    .sum_o   (Sum),
    .carry_o (ha2_carry)
  );

  // The two half-adder carries are mutually exclusive, so OR yields the full carry.
  or g_cout (Cout, ha1_carry, ha2_carry);

  logic             sum_q;
  logic             sum_d;
  logic             cout_q;
  logic             cout_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    sum_d  = Sum;
    cout_d = Cout;
    cnt_d  = cnt_q;
    // Count carry events but stick at all-ones instead of wrapping.
    if (Cout && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Sum_q     = sum_q;
  assign Cout_q    = cout_q;
  assign carry_cnt = cnt_q;
  assign carry_sat = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_full_adder_structural.sv
// tb/tb_full_adder_structural.sv - self-checking bench for full_adder_structural
module tb_full_adder_structural;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic       A = 1'b0;
  logic       B = 1'b0;
  logic       Cin = 1'b0;

  logic       sum8, cout8, sumq8, coutq8, sat8;
  logic [7:0] cnt8;
  logic       sum2, cout2, sumq2, coutq2, sat2;
  logic [1:0] cnt2;

  int vectors = 0;
  int miscompares = 0;

  // Reference state
  int m_sq = 0;
  int m_cq = 0;
  int m_c8 = 0;
  int m_c2 = 0;

  full_adder_structural #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .Sum(sum8), .Cout(cout8), .Sum_q(sumq8), .Cout_q(coutq8),
    .carry_cnt(cnt8), .carry_sat(sat8)
  );

  full_adder_structural #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .Sum(sum2), .Cout(cout2), .Sum_q(sumq2), .Cout_q(coutq2),
    .carry_cnt(cnt2), .carry_sat(sat2)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int total();
    return int'(A) + int'(B) + int'(Cin);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb();
    chk("sum8",  {15'd0, sum8},  16'(total() % 2));
    chk("cout8", {15'd0, cout8}, 16'(total() / 2));
    chk("sum2",  {15'd0, sum2},  16'(total() % 2));
    chk("cout2", {15'd0, cout2}, 16'(total() / 2));
  endtask

  task automatic chk_regs();
    chk("sumq8",  {15'd0, sumq8},  16'(m_sq));
    chk("coutq8", {15'd0, coutq8}, 16'(m_cq));
    chk("cnt8",   {8'd0, cnt8},    16'(m_c8));
    chk("sat8",   {15'd0, sat8},   16'(m_c8 == 255));
    chk("sumq2",  {15'd0, sumq2},  16'(m_sq));
    chk("coutq2", {15'd0, coutq2}, 16'(m_cq));
    chk("cnt2",   {14'd0, cnt2},   16'(m_c2));
    chk("sat2",   {15'd0, sat2},   16'(m_c2 == 3));
  endtask

  // One rising edge: advance the reference from the inputs present at the edge, then check.
  task automatic tick();
    int t;
    @(posedge clk);
    t = total();
    if (rst) begin
      m_sq = 0; m_cq = 0; m_c8 = 0; m_c2 = 0;
    end else begin
      m_sq = t % 2;
      m_cq = t / 2;
      if (m_cq == 1) begin
        if (m_c8 < 255) m_c8++;
        if (m_c2 < 3) m_c2++;
      end
    end
    #1;
    chk_comb();
    chk_regs();
  endtask

  task automatic set_in(input logic a, input logic b, input logic c);
    A = a; B = b; Cin = c;
  endtask

  initial begin
    logic [2:0] tt_in  [8];
    logic [1:0] tt_out [8];
    logic [2:0] r;
    tt_in  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    tt_out = '{2'b00,  2'b10,  2'b10,  2'b01,  2'b10,  2'b01,  2'b01,  2'b11};

    // Truth table with the clock idle; rst toggled to show it has no effect.
    for (int i = 0; i < 8; i++) begin
      r = tt_in[i];
      set_in(r[2], r[1], r[0]);
      rst = i[0];
      #10;
      chk("tt_sum",  {15'd0, sum8},  {15'd0, tt_out[i][1]});
      chk("tt_cout", {15'd0, cout8}, {15'd0, tt_out[i][0]});
      chk_comb();
    end

    // Reset state.
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b1);
    clk_run = 1'b1;
    tick();
    chk("rst_cnt8", {8'd0, cnt8}, 16'd0);

    // Registered latency.
    rst = 1'b0;
    #2;
    chk("lat_pre_sumq",  {15'd0, sumq8},  16'd0);
    chk("lat_pre_coutq", {15'd0, coutq8}, 16'd0);
    tick();
    chk("lat_sumq",  {15'd0, sumq8},  16'd1);
    chk("lat_coutq", {15'd0, coutq8}, 16'd1);

    // Counter counts carry edges, then holds.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    chk("cnt_five", {8'd0, cnt8}, 16'd5);
    set_in(1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("cnt_hold", {8'd0, cnt8}, 16'd5);

    // Reset priority over increment and load.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b0);
    repeat (2) tick();
    chk("pri_pre_cnt", {8'd0, cnt8}, 16'd2);
    rst = 1'b1;
    #2;
    chk("pri_mid_sum",  {15'd0, sum8},  16'd0);
    chk("pri_mid_cout", {15'd0, cout8}, 16'd1);
    tick();
    chk("pri_cnt",   {8'd0, cnt8},     16'd0);
    chk("pri_sumq",  {15'd0, sumq8},   16'd0);
    chk("pri_coutq", {15'd0, coutq8},  16'd0);
    chk("pri_sum",   {15'd0, sum8},    16'd0);
    chk("pri_cout",  {15'd0, cout8},   16'd1);

    // Saturation of the narrow counter.
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("sat_cnt2", {14'd0, cnt2}, 16'((k >= 3) ? 3 : k));
      chk("sat_flag2", {15'd0, sat2}, 16'(k >= 3));
    end

    // Random traffic with occasional reset and mid-cycle glitches on the inputs.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 15) == 0);
      #2;
      chk_comb();
      if ($urandom_range(0, 1) == 1) begin
        set_in(1'($urandom), 1'($urandom), 1'($urandom));
      end
      tick();
    end

    // Long carry run to reach saturation on the wide counter.
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b1);
    repeat (260) tick();
    chk("sat_cnt8", {8'd0, cnt8}, 16'd255);
    chk("sat_flag8", {15'd0, sat8}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
